// File: rtl/cdc_arb_pkg.sv
// +------------------------------------------------------------------+
// | cdc_arb_pkg : shared types and constants for cdc_tx_arbiter        |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

package cdc_arb_pkg;

  localparam int DATA_W          = 64;
  localparam int DEF_NUM_REQ     = 4;
  localparam int DEF_HOLD_CYCLES = 4;
  localparam int DEF_GAP_CYCLES  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_GAP  = 2'd2
  } state_e;

endpackage

`default_nettype wire

// File: rtl/cdc_arb_picker.sv
// +------------------------------------------------------------------+
// | cdc_arb_picker : combinational winner select, search from ptr_i    |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module cdc_arb_picker
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  // Rotating search: the first set request at or after ptr_i wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!any_o && req_i[(int'(ptr_i) + k) % NUM_REQ]) begin
        any_o = 1'b1;
        gnt_o[(int'(ptr_i) + k) % NUM_REQ] = 1'b1;
        idx_o = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/cdc_tx_arbiter.sv
// +------------------------------------------------------------------+
// | cdc_tx_arbiter : N-to-1 arbiter feeding a 64-bit hold/gap CDC path |
// | Option: CDC_ARB_FIXED_PRIO_EN selects fixed priority (lowest wins) |
// | Rev 1.0                                                            |
// +------------------------------------------------------------------+
`default_nettype none

module cdc_tx_arbiter
  import cdc_arb_pkg::*;
#(
  parameter int NUM_REQ     = DEF_NUM_REQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int GAP_CYCLES  = DEF_GAP_CYCLES
) (
  input  logic                      usb_clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [DATA_W-1:0]         usb_data_o,
  output logic                      usb_data_valid_o,
  output logic [$clog2(NUM_REQ)-1:0] grant_id_o,
  output logic                      busy_o
);

  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int MAX_PH = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CNT_W  = $clog2(MAX_PH + 1);

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DATA_W-1:0]   data_q;
  logic [ID_W-1:0]     gid_q;
  logic [ID_W-1:0]     ptr;
  logic [NUM_REQ-1:0]  pick_gnt;
  logic [ID_W-1:0]     pick_idx;
  logic                pick_any;
  logic                accept;

`ifdef CDC_ARB_FIXED_PRIO_EN
  assign ptr = '0;
`else
  logic [ID_W-1:0] ptr_q;
  assign ptr = ptr_q;

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
    end else if (accept) begin
      ptr_q <= (pick_idx == ID_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end
`endif

  cdc_arb_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (ID_W)
  ) u_picker (
    .req_i (req_valid_i),
    .ptr_i (ptr),
    .gnt_o (pick_gnt),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign accept = (state_q == ST_IDLE) && pick_any;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (pick_any) state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = ST_GAP;
          cnt_d   = '0;
        end
      end
      ST_GAP: begin
        if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge usb_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      data_q  <= '0;
      gid_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        data_q <= req_data_i[int'(pick_idx)*DATA_W +: DATA_W];
        gid_q  <= pick_idx;
      end
    end
  end

  // Ready is gated by rst_n so it is dead while reset is held.
  assign req_ready_o      = (accept && rst_n) ? pick_gnt : '0;
  assign usb_data_o       = data_q;
  assign grant_id_o       = gid_q;
  assign usb_data_valid_o = (state_q == ST_HOLD);
  assign busy_o           = (state_q != ST_IDLE);

endmodule

`default_nettype wire

// File: doc/cdc_tx_arbiter.md
CDC_TX_ARBITER -- requirements
Module: cdc_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing the 64-bit CDC channel (2..8).
REQ-002 SHALL have parameter HOLD_CYCLES, default 4: usb_clk cycles usb_data_valid_o stays high per transfer (>=1).
REQ-003 SHALL have parameter GAP_CYCLES, default 4: usb_clk cycles usb_data_valid_o stays low after each transfer (>=1).
REQ-004 SHALL have port usb_clk  in  1  sole clock; all logic rising-edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port req_valid_i  in  NUM_REQ  per-requester transfer request.
REQ-007 SHALL have port req_data_i  in  NUM_REQ*64  flattened request payloads; requester i occupies bits [64*i+63:64*i].
REQ-008 SHALL have port req_ready_o  out  NUM_REQ  one-hot acceptance strobe.
REQ-009 SHALL have port usb_data_o  out  64  payload to the CDC source side.
REQ-010 SHALL have port usb_data_valid_o  out  1  valid to the CDC source side.
REQ-011 SHALL have port grant_id_o  out  $clog2(NUM_REQ)  index of the requester owning the current transfer.
REQ-012 SHALL have port busy_o  out  1  high in any state other than IDLE.

Function
REQ-013 SHALL implement the states IDLE, HOLD and GAP.
REQ-014 In IDLE with any req_valid_i bit set, the block SHALL select one winner, assert req_ready_o[winner] combinationally in that cycle, capture its payload into usb_data_o, load grant_id_o and enter HOLD at the next edge.
REQ-015 req_ready_o SHALL be all-zero outside IDLE and high for exactly one cycle per accepted transfer.
REQ-016 In HOLD, usb_data_valid_o SHALL be 1 for exactly HOLD_CYCLES cycles, then the block SHALL enter GAP.
REQ-017 In GAP, usb_data_valid_o SHALL be 0 for exactly GAP_CYCLES cycles, then the block SHALL return to IDLE.
REQ-018 usb_data_o and grant_id_o SHALL stay stable from the capture edge until the next capture edge.
REQ-019 Latency SHALL be: request seen in IDLE -> usb_data_valid_o high on the following cycle; minimum transfer period 1+HOLD_CYCLES+GAP_CYCLES cycles.
REQ-020 Default arbitration SHALL be round-robin: the priority pointer starts at 0, after a grant to i the highest priority becomes (i+1) mod NUM_REQ, and the pointer SHALL be unchanged when nothing is granted.
REQ-021 Requests arriving or dropping while in HOLD or GAP SHALL be ignored until IDLE; a requester deasserting valid before its ready SHALL NOT be granted.
REQ-022 Requesters SHALL hold valid and data stable until ready; the block captures the payload only at the acceptance edge.
REQ-023 The phase counter SHALL be wide enough for max(HOLD_CYCLES,GAP_CYCLES) and SHALL reload to 0 on every state change.

Reset
REQ-024 rst_n low SHALL immediately force IDLE, usb_data_o=0, usb_data_valid_o=0, grant_id_o=0, busy_o=0, req_ready_o=0, pointer=0 and counter=0, including mid-HOLD or mid-GAP.
REQ-025 A transfer interrupted by reset SHALL be discarded and never replayed.

Configuration
REQ-026 With CDC_ARB_FIXED_PRIO_EN defined, arbitration SHALL be fixed priority (lowest index wins) and the round-robin pointer SHALL be omitted; without it, REQ-020 applies.

Structure
REQ-027 Package cdc_arb_pkg SHALL hold the state enum typedef, the data-width constant (64) and the default parameter constants.
REQ-028 The winner selection SHALL be a combinational sub-module cdc_arb_picker (request vector + pointer in, one-hot grant + index out); the pointer register stays in cdc_tx_arbiter.

Verification
REQ-029 Single request: req_valid_i=4'b0100, data 64'hDEAD_BEEF_0000_0002 -> ready[2] for 1 cycle, valid high for cycles 1-4, low for cycles 5-8, grant_id_o=2, data held throughout.
REQ-030 All four requesting continuously (round-robin) -> grant order 0,1,2,3,0; one grant every 9 cycles.
REQ-031 Same stimulus with CDC_ARB_FIXED_PRIO_EN -> requester 0 granted on every transfer.
REQ-032 req_valid_i[1] asserted during HOLD of requester 3 -> no ready until IDLE, then ready[1]; req[1] dropped before IDLE -> no grant.
REQ-033 rst_n pulsed low during cycle 2 of HOLD -> all outputs 0 asynchronously; after release with req_valid_i=4'b0001, requester 0 is granted (pointer reset).
